// File: rtl/program_sequencer_stack.sv
// Program sequencer: resolves the next fetch address and keeps the registered PC.
// Also handles a call/return stack, a single non-nesting interrupt, fetch stall and sticky stack-error flags.
module program_sequencer_stack #(
    parameter int              PC_W        = 8,
    parameter int              STACK_DEPTH = 4,
    parameter logic [PC_W-1:0] IRQ_VECTOR  = 8'hF0,
    localparam int             SP_W        = $clog2(STACK_DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            jmp,
    input  logic            jmp_nz,
    input  logic            dont_jmp,
    input  logic            call,
    input  logic            ret,
    input  logic            reti,
    input  logic            irq,
    input  logic [PC_W-1:0] jmp_addr,
    output logic [PC_W-1:0] pm_addr,
    output logic [PC_W-1:0] pc,
    output logic [SP_W-1:0] sp,
    output logic            in_isr,
    output logic            stack_ovf,
    output logic            stack_unf
);

    localparam int              IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SP_W-1:0] FULL  = SP_W'(STACK_DEPTH);

    logic [PC_W-1:0] stack_mem [0:(1 << IDX_W) - 1];
    logic            first_fetch;

    logic [PC_W-1:0] seq;
    logic [PC_W-1:0] branch_addr;
    logic [PC_W-1:0] top;
    logic [PC_W-1:0] push_data;
    logic            push_en;
    logic [SP_W-1:0] sp_next;
    logic            in_isr_next;
    logic            ovf_next;
    logic            unf_next;

    assign seq         = pc + PC_W'(1);
    assign top         = stack_mem[IDX_W'(sp - SP_W'(1))];
    assign branch_addr = (jmp || (jmp_nz && !dont_jmp)) ? jmp_addr : seq;

    // Strobes are resolved in fixed priority; a pending irq only wins over plain sequencing and jumps.
    always_comb begin
        pm_addr     = seq;
        sp_next     = sp;
        in_isr_next = in_isr;
        ovf_next    = stack_ovf;
        unf_next    = stack_unf;
        push_en     = 1'b0;
        push_data   = seq;

        if (first_fetch) begin
            pm_addr = '0;
        end else if (stall) begin
            pm_addr = pc;
        end else if (ret || reti) begin
            if (sp != '0) begin
                pm_addr = top;
                sp_next = sp - SP_W'(1);
            end else begin
                pm_addr  = seq;
                unf_next = 1'b1;
            end
            if (reti) begin
                in_isr_next = 1'b0;
            end
        end else if (call || (irq && !in_isr)) begin
            pm_addr   = call ? jmp_addr : IRQ_VECTOR;
            push_data = call ? seq : branch_addr;
            if (!call) begin
                in_isr_next = 1'b1;
            end
            if (sp < FULL) begin
                push_en = 1'b1;
                sp_next = sp + SP_W'(1);
            end else begin
                ovf_next = 1'b1;
            end
        end else begin
            pm_addr = branch_addr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            first_fetch <= 1'b1;
            pc          <= '0;
            sp          <= '0;
            in_isr      <= 1'b0;
            stack_ovf   <= 1'b0;
            stack_unf   <= 1'b0;
        end else begin
            first_fetch <= 1'b0;
            pc          <= pm_addr;
            sp          <= sp_next;
            in_isr      <= in_isr_next;
            stack_ovf   <= ovf_next;
            stack_unf   <= unf_next;
        end
    end

    // Stack storage is left unreset; entries are only read below the pointer.
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_mem[IDX_W'(sp)] <= push_data;
        end
    end

endmodule

// File: tb/tb_program_sequencer_stack.sv
// Directed bench for program_sequencer_stack with hand-computed expected values.
// A second narrow instance (PC_W=4) covers address wrap.
module tb_program_sequencer_stack;

    logic       clk;
    logic       reset;
    logic       stall, jmp, jmp_nz, dont_jmp, call, ret, reti, irq;
    logic [7:0] jmp_addr;
    logic [7:0] pm_addr, pc;
    logic [2:0] sp;
    logic       in_isr, stack_ovf, stack_unf;

    logic       w_jmp;
    logic [3:0] w_jmp_addr;
    logic [3:0] w_pm_addr, w_pc;
    logic [2:0] w_sp;
    logic       w_in_isr, w_ovf, w_unf;

    int check_count = 0;
    int error_count = 0;

    program_sequencer_stack #(.PC_W(8), .STACK_DEPTH(4), .IRQ_VECTOR(8'hF0)) dut (
        .clk(clk), .reset(reset), .stall(stall), .jmp(jmp), .jmp_nz(jmp_nz),
        .dont_jmp(dont_jmp), .call(call), .ret(ret), .reti(reti), .irq(irq),
        .jmp_addr(jmp_addr), .pm_addr(pm_addr), .pc(pc), .sp(sp),
        .in_isr(in_isr), .stack_ovf(stack_ovf), .stack_unf(stack_unf)
    );

    program_sequencer_stack #(.PC_W(4), .STACK_DEPTH(4), .IRQ_VECTOR(4'hC)) dut_narrow (
        .clk(clk), .reset(reset), .stall(1'b0), .jmp(w_jmp), .jmp_nz(1'b0),
        .dont_jmp(1'b0), .call(1'b0), .ret(1'b0), .reti(1'b0), .irq(1'b0),
        .jmp_addr(w_jmp_addr), .pm_addr(w_pm_addr), .pc(w_pc), .sp(w_sp),
        .in_isr(w_in_isr), .stack_ovf(w_ovf), .stack_unf(w_unf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s_call, input logic s_ret, input logic s_reti,
                                 input logic s_jmp, input logic [7:0] s_addr);
        call     = s_call;
        ret      = s_ret;
        reti     = s_reti;
        jmp      = s_jmp;
        jmp_addr = s_addr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; jmp = 1'b0; jmp_nz = 1'b0; dont_jmp = 1'b0;
        call = 1'b0; ret = 1'b0; reti = 1'b0; irq = 1'b0; jmp_addr = 8'h00;
        w_jmp = 1'b0; w_jmp_addr = 4'h0;

        #12;
        checkOutput("reset_pm", pm_addr, 0);
        checkOutput("reset_pc", pc, 0);
        checkOutput("reset_sp", sp, 0);
        checkOutput("reset_flags", {in_isr, stack_ovf, stack_unf}, 0);
        reset = 1'b1;
        #1;

        for (int i = 0; i < 5; i++) begin
            checkOutput("seq_pm", pm_addr, i);
            tick();
            checkOutput("seq_pc", pc, i);
        end

        jmp_nz = 1'b1; dont_jmp = 1'b1; jmp_addr = 8'h20; #1;
        checkOutput("jnz_not_taken", pm_addr, 8'h05);
        dont_jmp = 1'b0; #1;
        checkOutput("jnz_taken", pm_addr, 8'h20);
        tick();
        jmp_nz = 1'b0; stall = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h33);
        checkOutput("stall_pm", pm_addr, 8'h20);
        tick();
        checkOutput("stall_pc", pc, 8'h20);
        stall = 1'b0;

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h10);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h40);
        checkOutput("call_pm", pm_addr, 8'h40);
        tick();
        checkOutput("call_sp", sp, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        checkOutput("after_call_pc", pc, 8'h41);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("ret_pm", pm_addr, 8'h11);
        tick();
        checkOutput("ret_sp", sp, 0);

        // Nested calls from 0x11: return addresses 12, 51, 61, 71; fifth call overflows.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h50 + 8'(i * 16));
            checkOutput("ovf_before", stack_ovf, 0);
            tick();
            checkOutput("nest_sp", sp, (i < 4) ? i + 1 : 4);
        end
        checkOutput("ovf_set", stack_ovf, 1);
        checkOutput("ovf_pc", pc, 8'h90);
        begin
            logic [7:0] ret_expect [4] = '{8'h71, 8'h61, 8'h51, 8'h12};
            for (int i = 0; i < 4; i++) begin
                applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
                checkOutput("nest_ret_pm", pm_addr, ret_expect[i]);
                tick();
                checkOutput("nest_ret_sp", sp, 3 - i);
            end
        end
        checkOutput("unf_before", stack_unf, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("unf_pm", pm_addr, 8'h13);
        tick();
        checkOutput("unf_set", stack_unf, 1);
        checkOutput("unf_sp", sp, 0);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h05);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        irq = 1'b1; #1;
        checkOutput("irq_pm", pm_addr, 8'hF0);
        tick();
        checkOutput("irq_in_isr", in_isr, 1);
        checkOutput("irq_sp", sp, 1);
        checkOutput("no_reentry_pm", pm_addr, 8'hF1);
        tick();
        checkOutput("no_reentry_sp", sp, 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("reti_pm", pm_addr, 8'h06);
        tick();
        irq = 1'b0;
        checkOutput("reti_in_isr", in_isr, 0);
        checkOutput("reti_pc", pc, 8'h06);

        irq = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'hA0);
        checkOutput("irq_call_pm", pm_addr, 8'hA0);
        tick();
        checkOutput("irq_call_sp", sp, 1);
        checkOutput("irq_deferred", in_isr, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("irq_late_pm", pm_addr, 8'hF0);
        tick();
        checkOutput("irq_late_sp", sp, 2);
        checkOutput("irq_late_isr", in_isr, 1);

        #2 reset = 1'b0;
        #1;
        checkOutput("async_pm", pm_addr, 0);
        checkOutput("async_pc", pc, 0);
        checkOutput("async_sp", sp, 0);
        checkOutput("async_flags", {in_isr, stack_ovf, stack_unf}, 0);
        irq = 1'b0;
        tick();
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h55);
        checkOutput("first_fetch_pm", pm_addr, 0);
        tick();
        checkOutput("first_fetch_pc", pc, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        w_jmp = 1'b1; w_jmp_addr = 4'hF;
        tick();
        w_jmp = 1'b0; #1;
        checkOutput("wrap_pc", w_pc, 4'hF);
        checkOutput("wrap_pm", w_pm_addr, 4'h0);
        tick();
        checkOutput("wrap_pc_zero", w_pc, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
